// File: rtl/alu_req_driver.sv
// -----------------------------------------------------------------------------
// alu_req_driver
//
// Purpose:
//   Sequences single commands from a valid/ready request port onto an external
//   ALU and returns the result on a valid/ready response port. One command is
//   in flight at a time. Legal opcodes (0..8) are presented to the ALU for an
//   EXEC cycle and a FLAG cycle; the ALU's combinational result and its
//   registered flags are captured at the end of FLAG. Illegal opcodes (9..15)
//   bypass the ALU and produce an error response in the following cycle. This
//   block performs no arithmetic of its own.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   command handshake (ready only while idle)
//   req_a, req_b      operands            (WIDTH)
//   req_op            opcode              (4)
//   req_tag           caller ID           (4), echoed on rsp_tag
//   alu_a, alu_b      registered operands to the external ALU (WIDTH)
//   alu_op            registered opcode to the external ALU   (4)
//   alu_result        combinational ALU result                (WIDTH)
//   alu_zero/overflow ALU flags, registered inside the ALU
//   rsp_valid/ready   response handshake
//   rsp_result        captured result     (WIDTH)
//   rsp_zero/overflow captured flags
//   rsp_err           illegal opcode indicator
//   rsp_tag           echoed caller ID    (4)
//   cmd_count         completed responses, saturating (16)
// -----------------------------------------------------------------------------
module alu_req_driver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    input  logic [3:0]       req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [3:0]       rsp_tag,
    output logic [15:0]      cmd_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FLAG = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

    // Opcodes above GT have no ALU meaning and are answered with an error.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

    // Completed-response counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        logic [15:0] nxt;
        if (cnt != 16'hFFFF) begin
            nxt = cnt + 16'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    state_e           state_q,        state_d;
    logic             req_ready_q,    req_ready_d;
    logic             rsp_valid_q,    rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q,        alu_a_d;
    logic [WIDTH-1:0] alu_b_q,        alu_b_d;
    logic [3:0]       alu_op_q,       alu_op_d;
    logic [3:0]       tag_q,          tag_d;
    logic [WIDTH-1:0] rsp_result_q,   rsp_result_d;
    logic             rsp_zero_q,     rsp_zero_d;
    logic             rsp_overflow_q, rsp_overflow_d;
    logic             rsp_err_q,      rsp_err_d;
    logic [3:0]       rsp_tag_q,      rsp_tag_d;
    logic [15:0]      cmd_count_q,    cmd_count_d;

    // Next-state and datapath-load decisions for the command sequencer.
    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        tag_d          = tag_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        rsp_tag_d      = rsp_tag_q;
        cmd_count_d    = cmd_count_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (op_is_legal(req_op)) begin
                        alu_a_d  = req_a;
                        alu_b_d  = req_b;
                        alu_op_d = req_op;
                        tag_d    = req_tag;
                        state_d  = S_EXEC;
                    end else begin
                        // Illegal op: the ALU keeps its previous command and
                        // the error response is built directly.
                        rsp_result_d   = '0;
                        rsp_zero_d     = 1'b0;
                        rsp_overflow_d = 1'b0;
                        rsp_err_d      = 1'b1;
                        rsp_tag_d      = req_tag;
                        state_d        = S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                // The ALU registers its flags from the operands at this edge.
                state_d = S_FLAG;
            end
            S_FLAG: begin
                // Result is combinational on the held operands and the flags
                // became valid this cycle, so both are sampled together.
                rsp_result_d   = alu_result;
                rsp_zero_d     = alu_zero;
                rsp_overflow_d = alu_overflow;
                rsp_err_d      = 1'b0;
                rsp_tag_d      = tag_q;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cmd_count_d = sat_inc16(cmd_count_q);
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered decodes of the next state so that
        // they line up exactly with state_q after the edge.
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= 4'd0;
            tag_q          <= 4'd0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_tag_q      <= 4'd0;
            cmd_count_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            tag_q          <= tag_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            rsp_tag_q      <= rsp_tag_d;
            cmd_count_q    <= cmd_count_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_tag      = rsp_tag_q;
    assign cmd_count    = cmd_count_q;

endmodule
